// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Byte-serial program buffer and one-word-per-cycle sequencer that
//            feeds the mini RISC-V core, substituting a NOP when idle.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    load_data,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic          clear,
    input  logic          start,
    input  logic          loop,
    input  logic          halt,
    input  logic          stall,
    output logic [15:0]   instr,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done
);

    // Opcode 11 / funct3 000: the core writes nothing and returns x0.
    localparam logic [15:0] c_NOP  = 16'h0003;
    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          phase_q, phase_d;
    logic [7:0]    lo_q, lo_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          loop_q, loop_d;
    logic          drain_q, drain_d;
    logic [15:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          busy_q, busy_d;

    logic [15:0]   mem [DEPTH];
    logic          w_mem_we;
    logic [15:0]   w_mem_wdata;
    logic          w_last;

    assign w_last = ({1'b0, addr_q} == (count_q - 1'b1));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        phase_d     = phase_q;
        lo_d        = lo_q;
        addr_d      = addr_q;
        loop_d      = loop_q;
        drain_d     = drain_q;
        instr_d     = c_NOP;
        valid_d     = 1'b0;
        pc_d        = pc_q;
        busy_d      = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_wdata = {load_data, lo_q};

        unique case (state_q)
            S_IDLE: begin
                if (clear) begin
                    count_d = '0;
                    phase_d = 1'b0;
                end else if (start && (count_q != '0)) begin
                    // A dangling low byte is discarded on start.
                    loop_d  = loop;
                    phase_d = 1'b0;
                    addr_d  = '0;
                    drain_d = 1'b0;
                    state_d = S_RUN;
                end else if (load_valid && load_ready) begin
                    if (phase_q) begin
                        w_mem_we = 1'b1;
                        count_d  = count_q + 1'b1;
                        phase_d  = 1'b0;
                    end else begin
                        lo_d    = load_data;
                        phase_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d = S_IDLE;
                end else if (drain_q) begin
                    // Last word is on the bus now; present the NOP, then DONE.
                    state_d = S_DONE;
                end else begin
                    busy_d = 1'b1;
                    if (!stall) begin
                        instr_d = mem[addr_q];
                        valid_d = 1'b1;
                        pc_d    = addr_q;
                        if (w_last) begin
                            if (loop_q) begin
                                addr_d = '0;
                            end else begin
                                drain_d = 1'b1;
                            end
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            phase_q <= 1'b0;
            lo_q    <= '0;
            addr_q  <= '0;
            loop_q  <= 1'b0;
            drain_q <= 1'b0;
            instr_q <= c_NOP;
            valid_q <= 1'b0;
            pc_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            phase_q <= phase_d;
            lo_q    <= lo_d;
            addr_q  <= addr_d;
            loop_q  <= loop_d;
            drain_q <= drain_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            busy_q  <= busy_d;
        end
    end

    // Program storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[count_q[AW-1:0]] <= w_mem_wdata;
        end
    end

    assign load_ready  = (state_q == S_IDLE) && (count_q < c_FULL);
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign count       = count_q;
    assign busy        = busy_q;
    assign done        = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Directed stimulus with a queue-based scoreboard for instr_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [7:0]  load_data;
    logic        load_valid;
    logic        load_ready;
    logic        clear;
    logic        start;
    logic        loop;
    logic        halt;
    logic        stall;
    logic [15:0] instr;
    logic        instr_valid;
    logic [3:0]  pc;
    logic [4:0]  count;
    logic        busy;
    logic        done;

    instr_fetch #(.DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .clear      (clear),
        .start      (start),
        .loop       (loop),
        .halt       (halt),
        .stall      (stall),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [15:0] w;
        logic [3:0]  a;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w, input logic [3:0] a);
        exp_t e;
        e.w = w;
        e.a = a;
        sb_q.push_back(e);
    endtask

    task automatic load_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_data  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_start(input logic l);
        start = 1'b1;
        loop  = l;
        tick();
        start = 1'b0;
    endtask

    // Monitor: every issued word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (instr_valid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_issue: got %0h at pc %0d want no issue", instr, pc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("issue_instr", 32'(instr), 32'(e.w));
                    chk("issue_pc", 32'(pc), 32'(e.a));
                end
            end else begin
                chk("nop_instr", 32'(instr), 32'h0003);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_data = '0; load_valid = 1'b0; clear = 1'b0;
        start = 1'b0; loop = 1'b0; halt = 1'b0; stall = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_instr", 32'(instr), 32'h0003);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(load_ready), 1);
        mon_en = 1'b1;

        // Two-word program, plain replay
        load_byte(8'h05); load_byte(8'h60); load_byte(8'h09); load_byte(8'h81);
        chk("load2_count", 32'(count), 2);
        chk("load2_ready", 32'(load_ready), 1);
        push(16'h6005, 4'd0);
        push(16'h8109, 4'd1);
        do_start(1'b0);
        chk("run_busy_pre", 32'(busy), 0);
        tick();
        chk("run_busy_w0", 32'(busy), 1);
        tick();
        chk("run_busy_w1", 32'(busy), 1);
        chk("run_done_early", 32'(done), 0);
        tick();
        chk("run_done", 32'(done), 1);
        chk("run_busy_end", 32'(busy), 0);
        chk("run_ready_done", 32'(load_ready), 0);
        tick();
        chk("run_done_clr", 32'(done), 0);
        chk("run_ready_back", 32'(load_ready), 1);

        // Third word, looping replay with one stall cycle
        load_byte(8'h0B); load_byte(8'hA2);
        chk("load3_count", 32'(count), 3);
        push(16'h6005, 4'd0); push(16'h8109, 4'd1); push(16'hA20B, 4'd2);
        push(16'h6005, 4'd0); push(16'h8109, 4'd1);
        do_start(1'b1);
        tick();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        chk("stall_valid", 32'(instr_valid), 0);
        chk("stall_pc", 32'(pc), 0);
        tick(); tick(); tick(); tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_valid", 32'(instr_valid), 0);
        chk("halt_instr", 32'(instr), 32'h0003);
        chk("halt_busy", 32'(busy), 0);
        chk("halt_count", 32'(count), 3);
        chk("halt_ready", 32'(load_ready), 1);
        tick();
        chk("halt_idle_busy", 32'(busy), 0);

        // Dangling low byte, then start with a concurrent load offer
        load_byte(8'hEE);
        push(16'h6005, 4'd0); push(16'h8109, 4'd1); push(16'hA20B, 4'd2);
        start = 1'b1; loop = 1'b0; load_valid = 1'b1; load_data = 8'h77;
        tick();
        start = 1'b0; load_valid = 1'b0;
        chk("start_blocks_load", 32'(count), 3);
        repeat (5) tick();
        chk("odd_ready", 32'(load_ready), 1);
        load_byte(8'h44); load_byte(8'h33);
        chk("fresh_count", 32'(count), 4);
        push(16'h6005, 4'd0); push(16'h8109, 4'd1); push(16'hA20B, 4'd2);
        push(16'h3344, 4'd3);
        do_start(1'b0);
        repeat (6) tick();

        // Clear, then start on an empty buffer is ignored
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_count", 32'(count), 0);
        chk("clear_ready", 32'(load_ready), 1);
        do_start(1'b0);
        chk("empty_start_ready", 32'(load_ready), 1);
        tick();
        chk("empty_start_busy", 32'(busy), 0);
        chk("empty_start_done", 32'(done), 0);

        // Fill to capacity and beyond
        for (int i = 0; i < 32; i++) load_byte(8'(i));
        chk("full_count", 32'(count), 16);
        chk("full_ready", 32'(load_ready), 0);
        load_byte(8'hFF);
        chk("over_count", 32'(count), 16);
        chk("over_ready", 32'(load_ready), 0);
        for (int k = 0; k < 16; k++) push({8'(2*k+1), 8'(2*k)}, 4'(k));
        do_start(1'b0);
        repeat (17) tick();
        chk("full_done", 32'(done), 1);
        tick();
        chk("full_done_clr", 32'(done), 0);
        chk("full_ready_idle", 32'(load_ready), 0);

        // Reset in the middle of a looping replay
        push(16'h0100, 4'd0); push(16'h0302, 4'd1);
        do_start(1'b1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstrun_valid", 32'(instr_valid), 0);
        chk("rstrun_instr", 32'(instr), 32'h0003);
        chk("rstrun_count", 32'(count), 0);
        chk("rstrun_ready", 32'(load_ready), 1);
        chk("rstrun_busy", 32'(busy), 0);
        chk("rstrun_pc", 32'(pc), 0);

        repeat (3) tick();
        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Program buffer and instruction sequencer that sits directly upstream of the 16-bit mini RISC-V core. Each clock the core executes whatever 16-bit word it is presented, and it writes its register file on every non-`11` opcode. This block therefore owns the instruction stream. It captures a program byte-serially into a small word memory, then replays it one instruction per cycle. Whenever it is not issuing a real instruction it drives a safe NOP.

## Interface
- `DEPTH`, 16, number of 16-bit program words; power of two, ≥2.
- `AW`, 4, address width, log2(`DEPTH`).

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `load_data`  in  8  program byte.
- `load_valid`  in  1  byte offered.
- `load_ready`  out  1  byte accepted when `load_valid & load_ready`.
- `clear`  in  1  empty the buffer; IDLE only.
- `start`  in  1  begin replay; IDLE only.
- `loop`  in  1  sampled with `start`; replay repeats forever.
- `halt`  in  1  abort replay, return to IDLE.
- `stall`  in  1  hold sequencer for one cycle.
- `instr`  out  16  instruction to core; registered.
- `instr_valid`  out  1  `instr` is a program word, not NOP.
- `pc`  out  AW  address of the word on `instr`.
- `count`  out  AW+1  words loaded, 0..`DEPTH`.
- `busy`  out  1  state RUN.
- `done`  out  1  one-cycle pulse at end of non-loop replay.

## Operation
- NOP = `16'h0003`.
  - Opcode `11`, funct3 `000`: no register write; core result equals `x[0]`.
- States:
  - IDLE: load/clear/start accepted.
  - RUN: issuing.
  - DONE: one cycle, then IDLE.
- Loading (IDLE only):
  - `load_ready = (state==IDLE) & (count < DEPTH)`.
  - Bytes form words little-endian: first accepted byte → low byte, second → high byte.
  - A 1-bit `phase` flag tracks the half-word.
  - On the high byte, the word is written to `mem[count]` and `count` increments.
  - `count` saturates at `DEPTH`, and `load_ready` drops at full.
  - A pending low byte is held until its high byte arrives.
- Clear (IDLE only): `count←0`, `phase←0`; memory contents untouched. Ignored outside IDLE.
- Start (IDLE, `count≠0`):
  - `loop` is latched, `phase←0` (a dangling low byte is discarded), and the state goes to RUN with the sequencer at address 0.
  - Start with `count==0` is ignored and the state stays IDLE.
  - Priority in IDLE: `clear` over `start` over load. Load accept is blocked in a cycle where `start` is taken.
- RUN, each cycle:
  - `stall=1`: next `instr`=NOP, `instr_valid=0`, `pc` holds; nothing is skipped or repeated.
  - `stall=0`: next `instr=mem[addr]`, `instr_valid=1`, `pc=addr`, `addr` increments.
  - After issuing `addr==count-1`:
    - loop latched: `addr` wraps to 0, stays RUN.
    - not latched: go to DONE.
- `halt` in RUN or DONE: next state IDLE, next `instr`=NOP, `instr_valid=0`; overrides `stall`. It has no effect in IDLE.
- DONE: `instr`=NOP, `done=1` for exactly that cycle; next state IDLE.
- `load_valid` outside IDLE is ignored (`load_ready=0`).

## Timing
- Reset values (cycle after `rst` high):
  - state IDLE, `instr=16'h0003`, `instr_valid=0`, `pc=0`, `count=0`, `phase=0`, `busy=0`, `done=0`, `load_ready=1`.
  - Memory is not reset.
- Reset mid-RUN: NOP on the next edge; the program is lost (`count=0`).
- Latency: `start` sampled at edge N → `mem[0]` on `instr` after edge N+1.
  - An unstalled program of C words occupies edges N+1..N+C.
  - `done` is high after edge N+C+1.
  - `load_ready` returns after edge N+C+2.
- `busy` is high from edge N+1 through the last issued word's cycle.
- A stall raised in cycle k affects the word presented after edge k+1.
- Memory write occurs on the edge that accepts the high byte. `count` is visible after that edge.

## Test plan
- Load bytes `05,60`, `09,81` (two words) → `count=2`, `mem[0]=16'h6005`, `mem[1]=16'h8109`; `load_ready` stays 1.
- `start` with those 2 words, no stall → `instr` `6005`(pc0,valid), `8109`(pc1,valid), then NOP with `done`=1 one cycle, then IDLE; `busy` high exactly 2 cycles.
- 3 words, `loop=1`, `stall` asserted one cycle after the first issue → sequence `w0`, NOP(valid=0, pc=0), `w1`, `w2`, `w0`, …; no word is repeated or skipped across the wrap.
- Load 32 bytes with `DEPTH=16` → `count=16`, `load_ready=0`; a 33rd byte offered → not accepted, `count` unchanged.
- Odd byte then `start` → dangling byte dropped; the next two loaded bytes form a fresh word at `mem[count]`. `clear` then `start` → ignored, stays IDLE.
- `halt` mid-loop, and separately `rst` mid-RUN → NOP and `instr_valid=0` after the next edge. After `halt`, `count` is preserved. After `rst`, `count=0`, `load_ready=1`.
